// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the memory responder.
// The optional alignment check is enabled with the macro MEM_RSP_ALIGN_CHECK_EN.
package mem_rsp_pkg;

    localparam int WORD_W          = 32;
    localparam int ADDR_W          = 32;
    localparam int BYTE_W          = 8;
    localparam int LANES           = WORD_W / BYTE_W;
    localparam int DEPTH_DEFAULT   = 128;
    localparam int LATENCY_DEFAULT = 2;
    // Wide enough for the largest supported latency (15).
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // A byte address is word aligned when its two low bits are zero.
    function automatic logic addr_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/mem_rsp_array.sv
// Word storage for the memory responder, organised as four byte lanes.
// Synchronous write port and a registered read port whose output register
// can be cleared, so the responder can present zero data for stores/errors.
module mem_rsp_array
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [WORD_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic                     rd_clr_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [WORD_W-1:0]        rd_data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BYTE_W-1:0] lane_mem [DEPTH];
            logic [BYTE_W-1:0] lane_rd_q;

            // Store this lane's byte of the write word.
            always_ff @(posedge clk_i) begin
                if (wr_en_i) begin
                    lane_mem[wr_idx_i] <= wr_data_i[gi*BYTE_W +: BYTE_W];
                end
            end

            // Registered read; clear has priority so stale data never leaks out.
            always_ff @(posedge clk_i) begin
                if (rd_clr_i) begin
                    lane_rd_q <= '0;
                end else if (rd_en_i) begin
                    lane_rd_q <= lane_mem[rd_idx_i];
                end
            end

            assign rd_data_o[gi*BYTE_W +: BYTE_W] = lane_rd_q;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one load/store, waits a fixed
// latency, then presents a response held until the initiator takes it.
// Latency is counted from the accept cycle, so LATENCY=1 goes straight from
// IDLE to RESP and back-to-back requests repeat every LATENCY+1 cycles.
// Define MEM_RSP_ALIGN_CHECK_EN to reject addresses with addr[1:0] != 0.
module mem_responder
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WORD_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    localparam int               IDX_W       = $clog2(DEPTH);
    localparam bit               DIRECT_RESP = (LATENCY == 1);
    // WAIT lasts LATENCY-1 cycles; the counter terminates at zero.
    localparam logic [CNT_W-1:0] CNT_LOAD    = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              enter_resp;
    logic              handshake;
    logic              cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [IDX_W-1:0]  cur_idx;
    logic              out_of_range;
    logic              misaligned;
    logic              req_bad;
    logic              mem_wr_en;
    logic              mem_rd_en;
    logic              mem_rd_clr;
    logic [WORD_W-1:0] rd_data;

`ifndef MEM_RSP_ALIGN_CHECK_EN
    // Low address bits carry no meaning without the alignment check.
    logic unused_low_bits;
    assign unused_low_bits = ^cur_addr[1:0];
`endif

    // Decode the request being turned into a response this cycle: the live
    // inputs when responding straight from IDLE, otherwise the latched copy.
    always_comb begin
        accept     = req_valid_i & req_ready_q;
        handshake  = (state_q == RESP) & rsp_ready_i;
        enter_resp = (DIRECT_RESP & (state_q == IDLE) & accept)
                   | ((state_q == WAIT) & (cnt_q == '0));

        if (state_q == IDLE) begin
            cur_write = req_write_i;
            cur_addr  = req_addr_i;
            cur_wdata = req_wdata_i;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end

        cur_idx      = cur_addr[IDX_W+1:2];
        out_of_range = (cur_addr[ADDR_W-1:IDX_W+2] != '0);
`ifdef MEM_RSP_ALIGN_CHECK_EN
        misaligned   = addr_misaligned(cur_addr[1:0]);
`else
        misaligned   = 1'b0;
`endif
        req_bad      = out_of_range | misaligned;

        // Storage is touched only on entry to RESP and never while in reset,
        // so a reset during WAIT drops a pending store uncommitted.
        mem_wr_en  = rst_i & enter_resp & ~req_bad & cur_write;
        mem_rd_en  = rst_i & enter_resp & ~req_bad & ~cur_write;
        mem_rd_clr = ~rst_i | (enter_resp & (req_bad | cur_write)) | handshake;
    end

    // Next-state and next-output computation for the IDLE/WAIT/RESP machine.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_bad;
        end

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs; reset parks in IDLE ready for a request.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    mem_rsp_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk_i     (clk_i),
        .wr_en_i   (mem_wr_en),
        .wr_idx_i  (cur_idx),
        .wr_data_i (cur_wdata),
        .rd_en_i   (mem_rd_en),
        .rd_clr_i  (mem_rd_clr),
        .rd_idx_i  (cur_idx),
        .rd_data_o (rd_data)
    );

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rd_data;
    assign busy_o      = busy_q;

endmodule
